zihpm_counter_bank: RTL and testbench
=====================================

// Module: zihpm_counter_bank
// PURPOSE
//  Bank of NUM_COUNTERS programmable hardware performance counters (mhpmcounter3..N / mhpmevent3..N style).
//  Generalises the fixed cycle/instret counters: each counter has a run-time event selector and can be inhibited.
//  Each counter wraps on overflow, sets a sticky overflow flag, and raises an overflow interrupt request.
//  The bank holds its own counter state, sits beside the ZICSR file in the computational stage, and is fed by pipeline event strobes.
// PARAMETERS
//  XLEN           32  CSR data width (32 or 64)
//  NUM_COUNTERS   4   number of counters, 1..29
//  NUM_EVENTS     8   number of event strobe inputs, >=1
//  CNT_WIDTH      64  counter width, XLEN <= CNT_WIDTH <= 64
//  Derived: EVW = $clog2(NUM_EVENTS+1); IDXW = max(1,$clog2(NUM_COUNTERS))
// PORTS
//  clk            in   1             clock
//  reset          in   1             synchronous, active-low reset
//  EventVec       in   NUM_EVENTS    per-cycle event strobes; bit e = event e+1 occurred this cycle
//  CsrWriteEn     in   1             CSR write strobe, single cycle
//  CsrWriteSel    in   ZIHPMType::hpmSel  target: CNT_LO, CNT_HI, EVENT, INHIBIT, OVF
//  CsrWriteIdx    in   IDXW          counter index (ignored for INHIBIT/OVF)
//  CsrWriteData   in   XLEN          write data
//  CsrReadSel     in   ZIHPMType::hpmSel  read target
//  CsrReadIdx     in   IDXW          read counter index
//  CsrReadData    out  XLEN          combinational read of current (pre-update) state
//  OverflowFlags  out  NUM_COUNTERS  sticky overflow flags
//  OverflowIrq    out  1             registered OR of OverflowFlags & ~Inhibit
// BEHAVIOUR
//  Reset (reset==0 at clk edge):
//   - all counters, event selectors, Inhibit, OverflowFlags and OverflowIrq are cleared to 0.
//   - reset has priority over every other input, including a write or event in the same cycle.
//  Event select: Event[i]==0 means disabled. Event[i]==e in 1..NUM_EVENTS counts EventVec[e-1].
//   - Values > NUM_EVENTS are stored but count nothing.
//  Increment: when Inhibit[i]==0 and the selected strobe is 1, Cnt[i] <= Cnt[i]+1 at the next edge.
//   - Maximum +1 per cycle. Latency is one cycle: strobe in cycle t, visible on CsrReadData in cycle t+1.
//  Overflow: an increment from all-ones wraps Cnt[i] to 0 and sets OverflowFlags[i] in the same edge.
//   - OverflowIrq follows one cycle later.
//   - The flag stays set while the counter continues counting.
//  CSR writes, same-cycle rules:
//   - CNT_LO writes Cnt[i][XLEN-1:0]; CNT_HI (XLEN==32 only) writes Cnt[i][CNT_WIDTH-1:32].
//   - The untouched half keeps its pre-increment value.
//   - A counter write beats an increment of that counter in the same cycle: the increment is dropped and no overflow is set.
//   - CNT_HI write with XLEN==64 is ignored. Bits beyond CNT_WIDTH are discarded on write and read as 0.
//   - EVENT writes Event[i] <= Data[EVW-1:0]; the new selection takes effect the next cycle.
//   - INHIBIT writes Inhibit <= Data[NUM_COUNTERS-1:0]; it applies to increments from the next cycle.
//   - OVF is write-1-to-clear. If hardware sets and software clears the same flag in one cycle, the set wins.
//   - CsrWriteIdx >= NUM_COUNTERS: the write is ignored. CsrReadIdx >= NUM_COUNTERS: reads 0.
//  Reads:
//   - CNT_LO/CNT_HI return the counter halves; EVENT returns Event[i] zero-extended.
//   - INHIBIT and OVF return zero-extended vectors.
//   - A read in the same cycle as a write returns the old value (no bypass).
// STRUCTURE
//  Package ZIHPMType:
//   - enum hpmSel {CNT_LO, CNT_HI, EVENT, INHIBIT, OVF};
//   - struct hpmCounterCfg {EventSel, Inhibit}.
//  Sub-module zihpm_counter: one counter slice, generated NUM_COUNTERS times.
//   - Ports: event mux, increment, lo/hi write merge, overflow pulse.
//  Top level: write decode, sticky flag register, IRQ register, read mux.
// TESTING
//  1 Reset: hold reset=0 with EventVec all ones and a write pending -> all reads 0, OverflowIrq=0.
//  2 Count: Event[0]=3, assert EventVec[2] for 10 cycles -> Cnt0=10; Cnt1 (Event=0) stays 0.
//  3 Overflow: CNT_WIDTH=64 XLEN=32; write LO=FFFFFFFF and HI=FFFFFFFF, then one event
//     -> Cnt=0, OverflowFlags[0]=1, OverflowIrq=1 the next cycle. Write OVF=1 -> flag and IRQ clear.
//  4 Collision: write CNT_LO=0x100 in the same cycle as a selected event -> Cnt=0x100 (not 0x101).
//     OVF clear coincident with wrap -> flag stays 1.
//  5 Inhibit: Inhibit=0b0010 while events fire on counters 0 and 1 for 5 cycles
//     -> Cnt0=5, Cnt1 unchanged. Clearing the bit resumes counting the next cycle.
//  6 Out of range: CsrWriteIdx=NUM_COUNTERS, Data=0xDEAD -> no state change. Read of the same index -> 0.

Source files
------------

// File: rtl/zihpm_counter_bank_pkg.sv
// Shared types for the programmable performance-counter bank: CSR target select
// and the per-counter configuration record.
package ZIHPMType;

   localparam int EVSEL_W = 8;

   typedef enum logic [2:0] {
      CNT_LO  = 3'd0,
      CNT_HI  = 3'd1,
      EVENT   = 3'd2,
      INHIBIT = 3'd3,
      OVF     = 3'd4
   } hpmSel;

   typedef struct packed {
      logic [EVSEL_W-1:0] EventSel;
      logic               Inhibit;
   } hpmCounterCfg;

endpackage

// File: rtl/zihpm_counter_bank_if.sv
// CSR access and event strobe bundle between the pipeline/CSR file and the counter bank.
interface zihpm_counter_bank_if
   import ZIHPMType::*;
#(
   parameter int XLEN         = 32,
   parameter int NUM_COUNTERS = 4,
   parameter int NUM_EVENTS   = 8
);
   localparam int IDXW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;

   logic [NUM_EVENTS-1:0]   EventVec;
   logic                    CsrWriteEn;
   hpmSel                   CsrWriteSel;
   logic [IDXW-1:0]         CsrWriteIdx;
   logic [XLEN-1:0]         CsrWriteData;
   hpmSel                   CsrReadSel;
   logic [IDXW-1:0]         CsrReadIdx;
   logic [XLEN-1:0]         CsrReadData;
   logic [NUM_COUNTERS-1:0] OverflowFlags;
   logic                    OverflowIrq;

   modport master (
      output EventVec, CsrWriteEn, CsrWriteSel, CsrWriteIdx, CsrWriteData,
             CsrReadSel, CsrReadIdx,
      input  CsrReadData, OverflowFlags, OverflowIrq
   );

   modport slave (
      input  EventVec, CsrWriteEn, CsrWriteSel, CsrWriteIdx, CsrWriteData,
             CsrReadSel, CsrReadIdx,
      output CsrReadData, OverflowFlags, OverflowIrq
   );
endinterface

// File: rtl/zihpm_counter_bank_counter.sv
// One counter slice: event select, inhibitable increment, lo/hi write merge and
// a wrap pulse for the sticky overflow flag held in the bank.
module zihpm_counter
   import ZIHPMType::*;
#(
   parameter int XLEN       = 32,
   parameter int NUM_EVENTS = 8,
   parameter int CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] event_vec,
   input  hpmCounterCfg          cfg,
   input  logic                  wr_lo,
   input  logic                  wr_hi,
   input  logic [XLEN-1:0]       wr_data,
   output logic [CNT_WIDTH-1:0]  cnt,
   output logic                  ovf
);
   logic                 hit;
   logic                 inc;
   logic                 wr_any;
   logic [CNT_WIDTH-1:0] merged;

   always_comb begin
      hit = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
         if (cfg.EventSel == EVSEL_W'(e + 1)) hit = event_vec[e];
      end
   end

   assign inc    = hit & ~cfg.Inhibit;
   assign wr_any = wr_lo | wr_hi;
   // A software write owns the counter this cycle, so a coincident wrap is not an overflow.
   assign ovf    = inc & (&cnt) & ~wr_any;

   always_comb begin
      merged = cnt;
      for (int b = 0; b < CNT_WIDTH; b++) begin
         if (b < XLEN) begin
            if (wr_lo) merged[b] = wr_data[b];
         end else if (wr_hi) begin
            merged[b] = wr_data[b-32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)      cnt <= '0;
      else if (wr_any) cnt <= merged;
      else if (inc)    cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/zihpm_counter_bank.sv
// Bank of programmable performance counters: CSR write decode, sticky overflow
// flags, registered overflow interrupt and the combinational CSR read mux.
module zihpm_counter_bank
   import ZIHPMType::*;
#(
   parameter int XLEN         = 32,
   parameter int NUM_COUNTERS = 4,
   parameter int NUM_EVENTS   = 8,
   parameter int CNT_WIDTH    = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   zihpm_counter_bank_if.slave  bus
);
   localparam int EVW = $clog2(NUM_EVENTS + 1);

   logic [CNT_WIDTH-1:0]    cnt [NUM_COUNTERS];
   logic [EVW-1:0]          event_sel [NUM_COUNTERS];
   hpmCounterCfg            cfg [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0] inhibit;
   logic [NUM_COUNTERS-1:0] flags;
   logic [NUM_COUNTERS-1:0] ovf_set;
   logic [NUM_COUNTERS-1:0] ovf_clr;
   logic [NUM_COUNTERS-1:0] wr_lo;
   logic [NUM_COUNTERS-1:0] wr_hi;
   logic [NUM_COUNTERS-1:0] ev_we;
   logic                    irq;
   logic                    widx_ok;
   logic                    ridx_ok;
   logic [CNT_WIDTH-1:0]    cnt_r;
   logic [EVW-1:0]          ev_r;

   assign widx_ok = 32'(bus.CsrWriteIdx) < 32'(NUM_COUNTERS);
   assign ridx_ok = 32'(bus.CsrReadIdx) < 32'(NUM_COUNTERS);

   always_comb begin
      wr_lo   = '0;
      wr_hi   = '0;
      ev_we   = '0;
      ovf_clr = '0;
      if (bus.CsrWriteEn && bus.CsrWriteSel == OVF) ovf_clr = bus.CsrWriteData[NUM_COUNTERS-1:0];
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (bus.CsrWriteEn && widx_ok && 32'(bus.CsrWriteIdx) == i) begin
            wr_lo[i] = (bus.CsrWriteSel == CNT_LO);
            wr_hi[i] = (bus.CsrWriteSel == CNT_HI) && (XLEN == 32) && (CNT_WIDTH > 32);
            ev_we[i] = (bus.CsrWriteSel == EVENT);
         end
         cfg[i].EventSel = EVSEL_W'(event_sel[i]);
         cfg[i].Inhibit  = inhibit[i];
      end
   end

   for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
      zihpm_counter #(
         .XLEN       (XLEN),
         .NUM_EVENTS (NUM_EVENTS),
         .CNT_WIDTH  (CNT_WIDTH)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .event_vec (bus.EventVec),
         .cfg       (cfg[i]),
         .wr_lo     (wr_lo[i]),
         .wr_hi     (wr_hi[i]),
         .wr_data   (bus.CsrWriteData),
         .cnt       (cnt[i]),
         .ovf       (ovf_set[i])
      );
   end

   // Hardware set wins over a same-cycle write-1-to-clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         inhibit <= '0;
         flags   <= '0;
         irq     <= 1'b0;
         for (int i = 0; i < NUM_COUNTERS; i++) event_sel[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (ev_we[i]) event_sel[i] <= bus.CsrWriteData[EVW-1:0];
         end
         if (bus.CsrWriteEn && bus.CsrWriteSel == INHIBIT) inhibit <= bus.CsrWriteData[NUM_COUNTERS-1:0];
         flags <= (flags & ~ovf_clr) | ovf_set;
         irq   <= |(flags & ~inhibit);
      end
   end

   always_comb begin
      cnt_r = '0;
      ev_r  = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (32'(bus.CsrReadIdx) == i) begin
            cnt_r = cnt[i];
            ev_r  = event_sel[i];
         end
      end
      bus.CsrReadData = '0;
      case (bus.CsrReadSel)
         CNT_LO:  if (ridx_ok) bus.CsrReadData = cnt_r[XLEN-1:0];
         CNT_HI:  if (ridx_ok && XLEN == 32) bus.CsrReadData = XLEN'(cnt_r >> 32);
         EVENT:   if (ridx_ok) bus.CsrReadData = XLEN'(ev_r);
         INHIBIT: bus.CsrReadData = XLEN'(inhibit);
         OVF:     bus.CsrReadData = XLEN'(flags);
         default: bus.CsrReadData = '0;
      endcase
   end

   assign bus.OverflowFlags = flags;
   assign bus.OverflowIrq   = irq;
endmodule

// File: tb/tb_zihpm_counter_bank.sv
// Directed self-checking bench for zihpm_counter_bank (XLEN=32, 3 counters, 8 events, 64-bit counters).
module tb_zihpm_counter_bank;
   import ZIHPMType::*;

   localparam int XLEN = 32;
   localparam int NC   = 3;
   localparam int NE   = 8;
   localparam int CW   = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] r;
   int          n_checks = 0;
   int          n_fail   = 0;

   zihpm_counter_bank_if #(.XLEN(XLEN), .NUM_COUNTERS(NC), .NUM_EVENTS(NE)) bus ();

   zihpm_counter_bank #(.XLEN(XLEN), .NUM_COUNTERS(NC), .NUM_EVENTS(NE), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input hpmSel sel, input logic [1:0] idx, input logic [31:0] data);
      bus.CsrWriteEn   = 1'b1;
      bus.CsrWriteSel  = sel;
      bus.CsrWriteIdx  = idx;
      bus.CsrWriteData = data;
      tick();
      bus.CsrWriteEn   = 1'b0;
   endtask

   task automatic rd(input hpmSel sel, input logic [1:0] idx, output logic [31:0] data);
      bus.CsrReadSel = sel;
      bus.CsrReadIdx = idx;
      #1;
      data = bus.CsrReadData;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.EventVec     = '1;
      bus.CsrWriteEn   = 1'b1;
      bus.CsrWriteSel  = CNT_LO;
      bus.CsrWriteIdx  = 2'd0;
      bus.CsrWriteData = 32'hFFFF_FFFF;
      repeat (3) tick();
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL reset_cnt0: got %h expected %h", r, 32'h0); end
      rd(EVENT, 0, r); n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL reset_event0: got %h expected %h", r, 32'h0); end
      rd(INHIBIT, 0, r); n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL reset_inhibit: got %h expected %h", r, 32'h0); end
      n_checks++;
      if (bus.OverflowIrq !== 1'b0 || bus.OverflowFlags !== 3'b000) begin
         n_fail++; $display("FAIL reset_ovf: got irq=%b flags=%b expected irq=0 flags=000", bus.OverflowIrq, bus.OverflowFlags);
      end
      bus.CsrWriteEn = 1'b0;
      bus.EventVec   = '0;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_count();
      wr(EVENT, 0, 32'd3);
      bus.EventVec = 8'b0000_0100;
      tick();
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'd1) begin n_fail++; $display("FAIL count_latency: got %h expected %h", r, 32'd1); end
      repeat (9) tick();
      bus.EventVec = '0;
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'd10) begin n_fail++; $display("FAIL count_cnt0: got %h expected %h", r, 32'd10); end
      rd(CNT_HI, 0, r); n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL count_cnt0_hi: got %h expected %h", r, 32'd0); end
      rd(CNT_LO, 1, r); n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL count_cnt1: got %h expected %h", r, 32'd0); end
      rd(EVENT, 0, r); n_checks++;
      if (r !== 32'd3) begin n_fail++; $display("FAIL count_event_rd: got %h expected %h", r, 32'd3); end
      wr(EVENT, 0, 32'd0);
   endtask

   task automatic test_overflow();
      wr(CNT_LO, 0, 32'hFFFF_FFFF);
      wr(CNT_HI, 0, 32'hFFFF_FFFF);
      wr(EVENT, 0, 32'd1);
      rd(CNT_HI, 0, r); n_checks++;
      if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ovf_hi_write: got %h expected %h", r, 32'hFFFF_FFFF); end
      bus.EventVec = 8'b0000_0001;
      tick();
      bus.EventVec = '0;
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL ovf_wrap_lo: got %h expected %h", r, 32'h0); end
      rd(CNT_HI, 0, r); n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL ovf_wrap_hi: got %h expected %h", r, 32'h0); end
      n_checks++;
      if (bus.OverflowFlags !== 3'b001 || bus.OverflowIrq !== 1'b0) begin
         n_fail++; $display("FAIL ovf_flag_set: got flags=%b irq=%b expected flags=001 irq=0", bus.OverflowFlags, bus.OverflowIrq);
      end
      tick();
      n_checks++;
      if (bus.OverflowIrq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq_set: got %b expected 1", bus.OverflowIrq); end
      rd(OVF, 0, r); n_checks++;
      if (r !== 32'd1) begin n_fail++; $display("FAIL ovf_read: got %h expected %h", r, 32'd1); end
      wr(OVF, 0, 32'd1);
      n_checks++;
      if (bus.OverflowFlags !== 3'b000) begin n_fail++; $display("FAIL ovf_clear_flag: got %b expected 000", bus.OverflowFlags); end
      tick();
      n_checks++;
      if (bus.OverflowIrq !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_irq: got %b expected 0", bus.OverflowIrq); end
   endtask

   task automatic test_collision();
      bus.EventVec = 8'b0000_0001;
      wr(CNT_LO, 0, 32'h100);
      bus.EventVec = '0;
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'h100) begin n_fail++; $display("FAIL coll_write_wins: got %h expected %h", r, 32'h100); end
      wr(CNT_LO, 0, 32'hFFFF_FFFF);
      wr(CNT_HI, 0, 32'hFFFF_FFFF);
      bus.EventVec = 8'b0000_0001;
      wr(OVF, 0, 32'd1);
      bus.EventVec = '0;
      n_checks++;
      if (bus.OverflowFlags !== 3'b001) begin n_fail++; $display("FAIL coll_set_wins: got %b expected 001", bus.OverflowFlags); end
      wr(OVF, 0, 32'd1);
      tick();
      wr(CNT_HI, 0, 32'hFFFF_FFFF);
      wr(CNT_LO, 0, 32'hFFFF_FFFF);
      bus.EventVec = 8'b0000_0001;
      wr(CNT_LO, 0, 32'h5);
      bus.EventVec = '0;
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'h5) begin n_fail++; $display("FAIL coll_wrap_write_lo: got %h expected %h", r, 32'h5); end
      rd(CNT_HI, 0, r); n_checks++;
      if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL coll_untouched_hi: got %h expected %h", r, 32'hFFFF_FFFF); end
      n_checks++;
      if (bus.OverflowFlags !== 3'b000) begin n_fail++; $display("FAIL coll_no_ovf: got %b expected 000", bus.OverflowFlags); end
   endtask

   task automatic test_inhibit();
      wr(CNT_LO, 0, 32'h0);
      wr(CNT_HI, 0, 32'h0);
      wr(EVENT, 0, 32'd2);
      wr(EVENT, 1, 32'd2);
      wr(INHIBIT, 0, 32'b010);
      rd(INHIBIT, 0, r); n_checks++;
      if (r !== 32'b010) begin n_fail++; $display("FAIL inh_read: got %h expected %h", r, 32'b010); end
      bus.EventVec = 8'b0000_0010;
      repeat (5) tick();
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'd5) begin n_fail++; $display("FAIL inh_cnt0: got %h expected %h", r, 32'd5); end
      rd(CNT_LO, 1, r); n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL inh_cnt1_held: got %h expected %h", r, 32'd0); end
      wr(INHIBIT, 0, 32'b000);
      rd(CNT_LO, 1, r); n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL inh_clear_edge: got %h expected %h", r, 32'd0); end
      tick();
      bus.EventVec = '0;
      rd(CNT_LO, 1, r); n_checks++;
      if (r !== 32'd1) begin n_fail++; $display("FAIL inh_resume: got %h expected %h", r, 32'd1); end
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'd7) begin n_fail++; $display("FAIL inh_cnt0_final: got %h expected %h", r, 32'd7); end
   endtask

   task automatic test_out_of_range();
      wr(CNT_LO, 3, 32'hDEAD);
      wr(EVENT, 3, 32'hDEAD);
      rd(CNT_LO, 0, r); n_checks++;
      if (r !== 32'd7) begin n_fail++; $display("FAIL oor_cnt0: got %h expected %h", r, 32'd7); end
      rd(CNT_LO, 2, r); n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL oor_cnt2: got %h expected %h", r, 32'd0); end
      rd(EVENT, 0, r); n_checks++;
      if (r !== 32'd2) begin n_fail++; $display("FAIL oor_event0: got %h expected %h", r, 32'd2); end
      rd(CNT_LO, 3, r); n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL oor_read: got %h expected %h", r, 32'd0); end
      wr(EVENT, 2, 32'd9);
      bus.EventVec = '1;
      repeat (3) tick();
      bus.EventVec = '0;
      rd(EVENT, 2, r); n_checks++;
      if (r !== 32'd9) begin n_fail++; $display("FAIL evsel_stored: got %h expected %h", r, 32'd9); end
      rd(CNT_LO, 2, r); n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL evsel_counts_nothing: got %h expected %h", r, 32'd0); end
   endtask

   initial begin
      bus.EventVec     = '0;
      bus.CsrWriteEn   = 1'b0;
      bus.CsrWriteSel  = CNT_LO;
      bus.CsrWriteIdx  = '0;
      bus.CsrWriteData = '0;
      bus.CsrReadSel   = CNT_LO;
      bus.CsrReadIdx   = '0;
      reset = 1'b0;
      test_reset();
      test_count();
      test_overflow();
      test_collision();
      test_inhibit();
      test_out_of_range();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
